mic_capture_ctrl: RTL and testbench

- Sits directly downstream of the eight pdm_mic instances and upstream of the BRAM write port B inside system.
- Replaces free-running address_counter addressing with an armed, length-bounded capture:
  - on a software start edge, stores exactly N multi-channel sample frames, one frame per mic_data_valid pulse;
  - drives the BRAM byte address, write enable and registered channel data;
  - reports busy/done status back to the PS.

---
 rtl/mic_capture_ctrl.sv | 121 ++++++++++++
 tb/tb_mic_capture_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_capture_ctrl.sv
// Armed, length-bounded capture of multi-channel mic frames into BRAM port B.
// A start edge arms a capture of N frames; busy/done report progress to the PS.
module mic_capture_ctrl #(
    parameter int unsigned COUNT_WIDTH = 14,
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [COUNT_WIDTH:0]         num_samples_i,
    input  logic                         mic_data_valid_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din_i,
    output logic [31:0]                  addr_o,
    output logic [3:0]                   web_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] dout_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [COUNT_WIDTH:0]         sample_count_o
);

    localparam int unsigned DinW = NUM_CH * DATA_WIDTH;
    localparam logic [COUNT_WIDTH:0] FullLen = {1'b1, {COUNT_WIDTH{1'b0}}};

    typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

    state_e                 state_q, state_d;
    logic                   start_q;
    logic                   low_seen_q;
    logic [COUNT_WIDTH:0]   len_q, len_d;
    logic [COUNT_WIDTH-1:0] idx_q, idx_d;
    logic [COUNT_WIDTH:0]   count_q, count_d;
    logic [31:0]            addr_q, addr_d;
    logic [3:0]             web_q, web_d;
    logic [DinW-1:0]        dout_q, dout_d;
    logic                   busy_q, done_q;

    logic                   start_edge;
    logic [COUNT_WIDTH:0]   len_clamped;
    logic [COUNT_WIDTH+1:0] byte_idx;

    // low_seen_q suppresses a false edge when start is held high across reset release.
    assign start_edge  = start_i & ~start_q & low_seen_q;
    assign len_clamped = (num_samples_i == '0 || num_samples_i > FullLen) ? FullLen
                                                                           : num_samples_i;
    assign byte_idx    = {idx_q, 2'b00};

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        count_d = count_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        web_d   = 4'h0;
        if (abort_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_edge) begin
                        state_d = StCapture;
                        len_d   = len_clamped;
                        idx_d   = '0;
                        count_d = '0;
                    end
                end
                StCapture: begin
                    if (mic_data_valid_i) begin
                        web_d   = 4'hF;
                        addr_d  = 32'(byte_idx);
                        dout_d  = din_i;
                        idx_d   = idx_q + COUNT_WIDTH'(1);
                        count_d = count_q + (COUNT_WIDTH+1)'(1);
                        if (count_d == len_q) begin
                            state_d = StDone;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            low_seen_q <= 1'b0;
            len_q      <= FullLen;
            idx_q      <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            web_q      <= 4'h0;
            dout_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_i;
            low_seen_q <= low_seen_q | ~start_i;
            len_q      <= len_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            web_q      <= web_d;
            dout_q     <= dout_d;
            busy_q     <= (state_d == StCapture);
            done_q     <= (state_d == StDone);
        end
    end

    assign addr_o         = addr_q;
    assign web_o          = web_q;
    assign dout_o         = dout_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign sample_count_o = count_q;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Bench for mic_capture_ctrl: table-driven basic capture plus hand-written corner cases,
// with every BRAM write checked against a queue of expected {addr, data}.
module tb_mic_capture_ctrl;

    localparam int unsigned CW   = 14;
    localparam int unsigned NCH  = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned DinW = NCH * DW;

    logic            clk = 1'b0;
    logic            rstn;
    logic            start;
    logic            abort;
    logic [CW:0]     num_samples;
    logic            valid;
    logic [DinW-1:0] din;
    logic [31:0]     addr;
    logic [3:0]      web;
    logic [DinW-1:0] dout;
    logic            busy;
    logic            done;
    logic [CW:0]     sample_count;

    mic_capture_ctrl #(
        .COUNT_WIDTH(CW),
        .NUM_CH     (NCH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .start_i         (start),
        .abort_i         (abort),
        .num_samples_i   (num_samples),
        .mic_data_valid_i(valid),
        .din_i           (din),
        .addr_o          (addr),
        .web_o           (web),
        .dout_o          (dout),
        .busy_o          (busy),
        .done_o          (done),
        .sample_count_o  (sample_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     addr;
        logic [DinW-1:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] ch0;
        bit          wr;
        int          cnt;
        bit          busy;
        bit          done;
    } vec_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_idx = 0;

    task automatic chk(input string name, input logic [DinW-1:0] act,
                       input logic [DinW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every non-zero web must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rstn === 1'b1 && web !== 4'h0) begin
            wr_t w;
            chk("web_value", DinW'(web), DinW'(4'hF));
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", DinW'(addr), '1);
            end else begin
                w = exp_q.pop_front();
                chk("write_addr", DinW'(addr), DinW'(w.addr));
                chk("write_dout", dout, w.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DinW-1:0] mk_din(input logic [31:0] ch0);
        logic [DinW-1:0] d;
        d[31:0] = ch0;
        for (int k = 1; k < NCH; k++) d[k*DW +: DW] = $urandom;
        return d;
    endfunction

    task automatic push_exp(input logic [DinW-1:0] d);
        wr_t w;
        w.addr = 32'(exp_idx) << 2;
        w.data = d;
        exp_q.push_back(w);
        exp_idx++;
    endtask

    task automatic arm(input int n);
        start = 1'b0;
        num_samples = (CW+1)'(n);
        tick();
        start = 1'b1;
        tick();
        exp_idx = 0;
    endtask

    task automatic pulse(input logic [DinW-1:0] d, input bit exp_wr);
        din = d;
        valid = 1'b1;
        if (exp_wr) push_exp(d);
        tick();
        valid = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int cnt, input bit b, input bit dn);
        chk({tag, "_count"}, DinW'(sample_count), DinW'(cnt));
        chk({tag, "_busy"}, DinW'(busy), DinW'(b));
        chk({tag, "_done"}, DinW'(done), DinW'(dn));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, DinW'(addr), '0);
        chk({tag, "_web"}, DinW'(web), '0);
        chk({tag, "_dout"}, dout, '0);
        chk_status(tag, 0, 1'b0, 1'b0);
    endtask

    vec_t basic[5];

    initial begin
        for (int i = 0; i < 5; i++) begin
            basic[i].ch0  = 32'h11 + 32'(i);
            basic[i].wr   = (i < 4);
            basic[i].cnt  = (i < 4) ? i + 1 : 4;
            basic[i].busy = (i < 3);
            basic[i].done = (i >= 3);
        end

        rstn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        num_samples = '0;
        valid = 1'b0;
        din = '0;
        #12;
        chk_all_zero("reset");
        tick();
        rstn = 1'b1;
        tick();

        // Basic capture: four frames, fifth valid ignored
        arm(4);
        chk_status("basic_armed", 0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            pulse(mk_din(basic[i].ch0), basic[i].wr);
            chk_status($sformatf("basic_%0d", i), basic[i].cnt, basic[i].busy, basic[i].done);
            repeat (51) tick();
        end
        chk("basic_drained", DinW'(exp_q.size()), '0);

        // Abort on the 3rd valid, then restart at addr 0
        arm(10);
        pulse(mk_din(32'hA1), 1'b1);
        repeat (5) tick();
        pulse(mk_din(32'hA2), 1'b1);
        repeat (5) tick();
        din = mk_din(32'hA3);
        valid = 1'b1;
        abort = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        chk("abort_busy", DinW'(busy), '0);
        chk("abort_done", DinW'(done), '0);
        abort = 1'b0;
        arm(10);
        chk("abort_rearm_busy", DinW'(busy), DinW'(1'b1));
        pulse(mk_din(32'hA4), 1'b1);
        chk("abort_rearm_count", DinW'(sample_count), DinW'(1));
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_drained", DinW'(exp_q.size()), '0);

        // Start edge ignored mid-capture; num_samples change has no effect; re-arm from DONE
        arm(3);
        num_samples = (CW+1)'(1);
        pulse(mk_din(32'hB1), 1'b1);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk_status("ign_mid", 1, 1'b1, 1'b0);
        pulse(mk_din(32'hB2), 1'b1);
        tick();
        pulse(mk_din(32'hB3), 1'b1);
        chk_status("ign_end", 3, 1'b0, 1'b1);
        pulse(mk_din(32'hB4), 1'b0);
        chk("ign_hold_addr", DinW'(addr), DinW'(32'h8));
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        exp_idx = 0;
        chk_status("rearm", 0, 1'b1, 1'b0);
        pulse(mk_din(32'hB5), 1'b1);
        chk_status("rearm_len1", 1, 1'b0, 1'b1);
        tick();
        chk("ign_drained", DinW'(exp_q.size()), '0);

        // Back-to-back valids
        arm(3);
        for (int i = 0; i < 3; i++) begin
            din = mk_din(32'hC0 + 32'(i));
            valid = 1'b1;
            push_exp(din);
            tick();
        end
        valid = 1'b0;
        chk_status("b2b", 3, 1'b0, 1'b1);
        tick();
        chk("b2b_drained", DinW'(exp_q.size()), '0);

        // Full depth
        arm(0);
        for (int i = 0; i < (1 << CW); i++) begin
            din = mk_din($urandom);
            valid = 1'b1;
            push_exp(din);
            tick();
        end
        valid = 1'b0;
        chk_status("full", 1 << CW, 1'b0, 1'b1);
        chk("full_last_addr", DinW'(addr), DinW'(32'hFFFC));
        tick();
        pulse(mk_din(32'hD0), 1'b0);
        tick();
        chk("full_drained", DinW'(exp_q.size()), '0);

        // Reset mid-capture with start held high
        arm(5);
        pulse(mk_din(32'hE1), 1'b1);
        repeat (3) tick();
        pulse(mk_din(32'hE2), 1'b1);
        repeat (3) tick();
        rstn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        chk("rst_no_edge_busy", DinW'(busy), '0);
        pulse(mk_din(32'hE3), 1'b0);
        chk("rst_no_write_count", DinW'(sample_count), '0);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        exp_idx = 0;
        chk("rst_rearm_busy", DinW'(busy), DinW'(1'b1));
        pulse(mk_din(32'hE4), 1'b1);
        repeat (2) tick();
        chk("rst_rearm_count", DinW'(sample_count), DinW'(1));
        chk("final_drained", DinW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
